// File: rtl/counter_pkg.sv
// Shared definitions for the counter-sharing arbiter family.
//   - state encoding for the IDLE / COUNT / DONE sequencer
//   - default counter width used when a top does not override WIDTH
package counter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_COUNT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT,
    S_DONE  = ST_DONE
  } state_e;

endpackage

// File: rtl/counter_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
// Searches req_i upward starting at pointer_i+1, wrapping modulo NREQ, and
// returns the first set bit. The requester at pointer_i itself is checked last.
//   req_i      NREQ    request vector
//   pointer_i  IW      last-served index
//   onehot_o   NREQ    one-hot winner (zero when no request)
//   idx_o      IW      winner index (zero when no request)
//   valid_o    1       at least one request present
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   pointer_i,
  output logic [NREQ-1:0] onehot_o,
  output logic [IW-1:0]   idx_o,
  output logic            valid_o
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(pointer_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        idx_o          = cand;
        onehot_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_share_arbiter.sv
// counter_share_arbiter: shares one WIDTH-bit up-counter between NREQ
// requesters. A round-robin winner is granted, its length is latched, the
// counter runs 0..target, and a one-cycle done pulse goes back to the winner.
//   clk   system clock
//   rst   asynchronous active-low reset
//   req   per-requester level request, held until done or cancel
//   len   packed lengths, slice i = len[i*WIDTH +: WIDTH], sampled at grant
//   gnt   one-hot grant while the interval is counting
//   busy  high in COUNT and DONE
//   cnt   shared counter value
//   done  one-cycle one-hot completion pulse
// All outputs are registered.
module counter_share_arbiter
  import counter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt,
  output logic [NREQ-1:0]       done
);

  localparam int IW = $clog2(NREQ);

  state_e             state_q;
  logic [IW-1:0]      ptr_q;
  logic [IW-1:0]      win_q;
  logic [WIDTH-1:0]   target_q;
  logic [WIDTH-1:0]   cnt_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    done_q;
  logic               busy_q;

  logic [NREQ-1:0]    pick_onehot;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic [WIDTH-1:0]   len_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len[i*WIDTH +: WIDTH];
  end

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .req_i     (req),
    .pointer_i (ptr_q),
    .onehot_o  (pick_onehot),
    .idx_o     (pick_idx),
    .valid_o   (pick_valid)
  );

  // Pointer resets to NREQ-1 so requester 0 wins the first arbitration.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: every register here is small control state and is reset; there
    // is no storage array that could be left unreset.
    if (!rst) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      win_q    <= '0;
      target_q <= '0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= '0;
          cnt_q  <= '0;
          if (pick_valid) begin
            state_q  <= S_COUNT;
            gnt_q    <= pick_onehot;
            win_q    <= pick_idx;
            target_q <= len_arr[pick_idx];
            busy_q   <= 1'b1;
          end else begin
            gnt_q  <= '0;
            busy_q <= 1'b0;
          end
        end

        S_COUNT: begin
          // Cancel is checked first so it wins over a same-cycle completion.
          if (!req[win_q]) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= win_q;
          end else if (cnt_q == target_q) begin
            state_q <= S_DONE;
            done_q  <= gnt_q;
            gnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          ptr_q   <= win_q;
        end

        default: begin
          state_q <= S_IDLE;
          gnt_q   <= '0;
          done_q  <= '0;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign cnt  = cnt_q;

endmodule

// File: doc/counter_share_arbiter.md
Name: counter_share_arbiter

Overview:
- Shares one WIDTH-bit synchronous up-counter between NREQ requesters.
- Each requester asks for a count interval of programmable length.
- The block arbitrates round-robin, loads and sequences the shared counter, and returns a one-cycle done pulse to the winner.
- Sits between the timing/counter datapath and client blocks that need delays or event spacing.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 4, counter and length width in bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester level request; held until done or cancel.
- len  input  NREQ*WIDTH  packed target lengths; slice i = len[i*WIDTH +: WIDTH]; sampled only at grant.
- gnt  output  NREQ  one-hot grant; all zero when no interval is active.
- busy  output  1  high while in COUNT or DONE.
- cnt  output  WIDTH  current shared counter value.
- done  output  NREQ  one-cycle one-hot pulse on completion for the granted requester.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; gnt=0, done=0, busy=0, cnt=0.
  - Round-robin pointer=NREQ-1, so requester 0 has first priority.
  - Latched target=0.
  - Reset release is synchronous to clk.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - Next edge: state=COUNT, gnt=onehot(winner), target=len slice of winner, cnt=0, busy=1.
  - If no req bit is set, remain in IDLE with outputs 0.
- COUNT:
  - If req[winner]=0: cancel. Next edge: state=IDLE, gnt=0, cnt=0, busy=0, no done pulse, pointer=winner.
  - Else if cnt==target: next edge state=DONE, done=onehot(winner), gnt=0, cnt holds.
  - Else: cnt=cnt+1 each cycle.
  - Cancel takes precedence over completion in the same cycle.
- DONE:
  - Lasts exactly one cycle with busy=1.
  - Next edge: state=IDLE, done=0, cnt=0, busy=0, pointer=winner.
- Latency:
  - Req sampled in IDLE at cycle T; gnt high from T+1.
  - done high in cycle T+target+2. gnt is high for target+1 cycles.
  - len=0 gives one COUNT cycle; done at T+2.
- Width rules:
  - cnt never exceeds target, so it never wraps.
  - Maximum target 2^WIDTH-1 (15 at default).
- Changes to len after grant are ignored.
- Requests arriving during COUNT or DONE wait. There is always a one-cycle IDLE bubble between intervals.
- Multiple simultaneous requests: exactly one is granted; the others are served in round-robin order on later intervals.
- A req that is never granted has no side effect.
- Fairness: with all NREQ requesters continuously asserting, each is granted once every NREQ intervals.
- Reset during COUNT or DONE: immediate return to reset values; no done pulse is issued.
- Outputs gnt, done, busy and cnt are all registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package (counter_pkg): state encoding localparams for IDLE/COUNT/DONE, and a default WIDTH constant.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req, pointer.
  - Outputs: one-hot winner and its index.
  - Reusable by other arbiters in the codebase.
- The counter, the target register and the FSM stay in counter_share_arbiter.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req=4'b1111 -> gnt=0, done=0, cnt=0, busy=0; assert rst=0 mid-COUNT (cnt=5) -> all outputs 0 immediately, no done.
- Single request: req=4'b0001, len0=3 -> gnt=0001 from T+1 for 4 cycles, cnt sequence 0,1,2,3, done=0001 at T+5, then IDLE.
- Zero length: req=4'b0100, len2=0 -> gnt=0100 for 1 cycle, cnt=0, done=0100 at T+2.
- Round robin: req=4'b1111 held, all len=1 -> grant order 0,1,2,3,0; each done 4 cycles apart (3 busy + 1 IDLE bubble).
- Cancel: req=4'b0010, len1=10; drop req[1] when cnt=4 -> next edge gnt=0, cnt=0, no done; pending req[2] is granted next.
- Max length/len change: len3=15, change len3 to 2 after grant -> counts 0..15, done at T+17, cnt never wraps.
